// File: rtl/timer_pkg.sv
// Shared encodings, limits and a clamp helper for the countdown timer datapath.
package timer_pkg;

  localparam int TIME_W = 7;

  localparam logic [TIME_W-1:0] MAX_HORA   = 7'd23;
  localparam logic [TIME_W-1:0] MAX_MINSEC = 7'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] val,
                                                   input logic [TIME_W-1:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/countdown_sequencer_tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_COUNT enabled cycles; holds while disabled.
module tick_prescaler #(
  parameter int TICK_COUNT = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_COUNT - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = enable && !clear && (cnt_r == LAST);

  // Cycle counter: clear wins, otherwise counts while enabled and wraps on the tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= CNT_W'(0);
    end else if (clear) begin
      cnt_r <= CNT_W'(0);
    end else if (enable) begin
      if (cnt_r == LAST) begin
        cnt_r <= CNT_W'(0);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Run/pause/done sequencer for an HH:MM:SS countdown.
// Define COUNTDOWN_ALARM_BLINK_EN to blink alarm in DONE instead of holding it steady.
module countdown_sequencer
  import timer_pkg::*;
#(
  parameter int TICK_COUNT = 100_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              load,
  input  logic [TIME_W-1:0] hora_in,
  input  logic [TIME_W-1:0] min_in,
  input  logic [TIME_W-1:0] sec_in,
  output logic [TIME_W-1:0] hora_left,
  output logic [TIME_W-1:0] min_left,
  output logic [TIME_W-1:0] sec_left,
  output logic [1:0]        state,
  output logic              running,
  output logic              done,
  output logic              alarm
);

  state_t            state_r, state_nxt_s;
  logic [TIME_W-1:0] hora_r, min_r, sec_r;
  logic [TIME_W-1:0] hora_nxt_s, min_nxt_s, sec_nxt_s;
  logic [TIME_W-1:0] dec_hora_s, dec_min_s, dec_sec_s;
  logic              dec_zero_s, nonzero_s, tick_s, pre_clear_s, pre_enable_s;

  assign nonzero_s = (hora_r != 7'd0) || (min_r != 7'd0) || (sec_r != 7'd0);

  // Prescaler runs only in RUN, so PAUSE keeps the partial second.
  assign pre_enable_s = (state_r == ST_RUN);
  assign pre_clear_s  = (state_r == ST_IDLE) || (state_r == ST_DONE) ||
                        (load && (state_r == ST_PAUSE));

  tick_prescaler #(.TICK_COUNT(TICK_COUNT)) u_sec_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (pre_enable_s),
    .clear  (pre_clear_s),
    .tick   (tick_s)
  );

  // One-second borrow chain: seconds, then minutes, then hours.
  always_comb begin
    dec_hora_s = hora_r;
    dec_min_s  = min_r;
    dec_sec_s  = sec_r;
    if (sec_r != 7'd0) begin
      dec_sec_s = sec_r - 7'd1;
    end else if (min_r != 7'd0) begin
      dec_sec_s = MAX_MINSEC;
      dec_min_s = min_r - 7'd1;
    end else if (hora_r != 7'd0) begin
      dec_sec_s  = MAX_MINSEC;
      dec_min_s  = MAX_MINSEC;
      dec_hora_s = hora_r - 7'd1;
    end else begin
      dec_sec_s = sec_r;
    end
    dec_zero_s = (dec_hora_s == 7'd0) && (dec_min_s == 7'd0) && (dec_sec_s == 7'd0);
  end

  // Next-state and time update; load beats start wherever it is accepted.
  always_comb begin
    state_nxt_s = state_r;
    hora_nxt_s  = hora_r;
    min_nxt_s   = min_r;
    sec_nxt_s   = sec_r;
    case (state_r)
      ST_IDLE, ST_PAUSE, ST_DONE: begin
        if (load) begin
          state_nxt_s = ST_IDLE;
          hora_nxt_s  = clamp_time(hora_in, MAX_HORA);
          min_nxt_s   = clamp_time(min_in, MAX_MINSEC);
          sec_nxt_s   = clamp_time(sec_in, MAX_MINSEC);
        end else if (start) begin
          if (state_r == ST_DONE) begin
            state_nxt_s = ST_IDLE;
          end else if (state_r == ST_PAUSE) begin
            state_nxt_s = ST_RUN;
          end else if (nonzero_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (start) begin
          state_nxt_s = ST_PAUSE;
        end else if (tick_s) begin
          hora_nxt_s  = dec_hora_s;
          min_nxt_s   = dec_min_s;
          sec_nxt_s   = dec_sec_s;
          state_nxt_s = dec_zero_s ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and remaining-time registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      hora_r  <= 7'd0;
      min_r   <= 7'd0;
      sec_r   <= 7'd0;
    end else begin
      state_r <= state_nxt_s;
      hora_r  <= hora_nxt_s;
      min_r   <= min_nxt_s;
      sec_r   <= sec_nxt_s;
    end
  end

  assign hora_left = hora_r;
  assign min_left  = min_r;
  assign sec_left  = sec_r;
  assign state     = state_r;
  assign running   = (state_r == ST_RUN);
  assign done      = (state_r == ST_DONE);

`ifdef COUNTDOWN_ALARM_BLINK_EN
  logic blink_tick_s, blink_clear_s, blink_enable_s, alarm_r;

  assign blink_enable_s = (state_r == ST_DONE);
  assign blink_clear_s  = (state_r != ST_DONE);

  tick_prescaler #(.TICK_COUNT(TICK_COUNT / 2)) u_blink_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (blink_enable_s),
    .clear  (blink_clear_s),
    .tick   (blink_tick_s)
  );

  // Alarm rises on DONE entry, toggles on each half-period tick, drops on exit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alarm_r <= 1'b0;
    end else if (state_nxt_s != ST_DONE) begin
      alarm_r <= 1'b0;
    end else if (state_r != ST_DONE) begin
      alarm_r <= 1'b1;
    end else if (blink_tick_s) begin
      alarm_r <= ~alarm_r;
    end else begin
      alarm_r <= alarm_r;
    end
  end

  assign alarm = alarm_r;
`else
  assign alarm = (state_r == ST_DONE);
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed, table-driven bench for countdown_sequencer with TICK_COUNT=4.
module tb_countdown_sequencer;

  logic       clock, reset, start, load;
  logic [6:0] hora_in, min_in, sec_in;
  logic [6:0] hora_left, min_left, sec_left;
  logic [1:0] state;
  logic       running, done, alarm;

  int checks = 0;
  int errors = 0;

  countdown_sequencer #(.TICK_COUNT(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .load      (load),
    .hora_in   (hora_in),
    .min_in    (min_in),
    .sec_in    (sec_in),
    .hora_left (hora_left),
    .min_left  (min_left),
    .sec_left  (sec_left),
    .state     (state),
    .running   (running),
    .done      (done),
    .alarm     (alarm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic [6:0] h, m, s;
    logic [6:0] eh, em, es;
    logic [1:0] est;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic st, input logic [6:0] h, input logic [6:0] m,
                     input logic [6:0] s, input logic [6:0] eh, input logic [6:0] em,
                     input logic [6:0] es, input logic [1:0] est);
    vec_t v;
    v.ld = ld; v.st = st; v.h = h; v.m = m; v.s = s;
    v.eh = eh; v.em = em; v.es = es; v.est = est;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [6:0] eh, input logic [6:0] em,
                           input logic [6:0] es, input logic [1:0] est);
    check({name, "_hora"}, hora_left, eh);
    check({name, "_min"}, min_left, em);
    check({name, "_sec"}, sec_left, es);
    check({name, "_state"}, state, est);
    check({name, "_running"}, running, est == 2'd1);
    check({name, "_done"}, done, est == 2'd3);
`ifdef COUNTDOWN_ALARM_BLINK_EN
    if (est != 2'd3) check({name, "_alarm"}, alarm, 0);
`else
    check({name, "_alarm"}, alarm, est == 2'd3);
`endif
  endtask

  // Drive one cycle's inputs, let the edge happen, then release the pulses.
  task automatic cycle(input logic ld, input logic st, input logic [6:0] h,
                       input logic [6:0] m, input logic [6:0] s);
    load = ld; start = st; hora_in = h; min_in = m; sec_in = s;
    @(posedge clock); #1;
    load = 1'b0; start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; load = 1'b0;
    hora_in = 7'd0; min_in = 7'd0; sec_in = 7'd0;
    #3;
    check_all("por", 7'd0, 7'd0, 7'd0, 2'd0);
    #19 reset = 1'b1;

    // Asynchronous reset in the middle of a run.
    cycle(1'b1, 1'b0, 7'd0, 7'd0, 7'd5);
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    check_all("pre_rst", 7'd0, 7'd0, 7'd5, 2'd1);
    #2 reset = 1'b0;
    #1 check_all("mid_rst", 7'd0, 7'd0, 7'd0, 2'd0);
    #1 reset = 1'b1;
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    check_all("zero_start", 7'd0, 7'd0, 7'd0, 2'd0);

    // Table: basic countdown, cascaded borrow, clamping, load/start collisions.
    add(1, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 59, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 59, 1);
    add(0, 0, 0, 0, 0, 0, 0, 58, 1);
    add(0, 1, 0, 0, 0, 0, 0, 58, 2);
    add(1, 0, 1, 0, 1, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 59, 59, 1);
    add(0, 1, 0, 0, 0, 0, 59, 59, 2);
    add(1, 0, 30, 75, 99, 23, 59, 59, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 2, 0, 0, 2, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].ld, vecs[i].st, vecs[i].h, vecs[i].m, vecs[i].s);
      check_all($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].est);
    end

    // Load during RUN is ignored.
    cycle(1'b1, 1'b0, 7'd0, 7'd0, 7'd3);
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    cycle(1'b1, 1'b0, 7'd0, 7'd5, 7'd0);
    check_all("run_load", 7'd0, 7'd0, 7'd3, 2'd1);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    check_all("run_load_hold", 7'd0, 7'd0, 7'd3, 2'd1);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    check_all("run_load_tick", 7'd0, 7'd0, 7'd2, 2'd1);

    // Pause preserves the partial second.
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    cycle(1'b1, 1'b0, 7'd0, 7'd0, 7'd2);
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    check_all("pause", 7'd0, 7'd0, 7'd2, 2'd2);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
      check($sformatf("paused%0d_sec", k), sec_left, 2);
      check($sformatf("paused%0d_state", k), state, 2);
    end
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    check_all("resume", 7'd0, 7'd0, 7'd2, 2'd1);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    check_all("resume_1", 7'd0, 7'd0, 7'd2, 2'd1);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    check_all("resume_2", 7'd0, 7'd0, 7'd1, 2'd1);

    // Expiry, alarm and acknowledge.
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    cycle(1'b1, 1'b0, 7'd0, 7'd0, 7'd1);
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
      check_all($sformatf("pre_done%0d", k), 7'd0, 7'd0, 7'd1, 2'd1);
    end
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    check_all("done_entry", 7'd0, 7'd0, 7'd0, 2'd3);
    check("done_entry_alarm", alarm, 1);
`ifdef COUNTDOWN_ALARM_BLINK_EN
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    check("blink_1", alarm, 1);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    check("blink_2", alarm, 0);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    check("blink_4", alarm, 1);
`else
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
      check_all($sformatf("done_hold%0d", k), 7'd0, 7'd0, 7'd0, 2'd3);
    end
`endif
    cycle(1'b0, 1'b1, 7'd0, 7'd0, 7'd0);
    check_all("ack", 7'd0, 7'd0, 7'd0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
